// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side sequencer.
// Holds instruction/operand types, reader FSM states and LFSR helper.
package instr_register_pkg;

    localparam int DEPTH     = 32;
    localparam int CNT_W     = 6;
    localparam int CNT_SAT_W = 16;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] operand_d;
    typedef logic [4:0]         address_t;

    typedef enum logic [2:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        operand_d rezultat;
    } instruction_t;

    typedef enum logic [1:0] {
        RD_INCR = 2'd0,
        RD_DECR = 2'd1,
        RD_RAND = 2'd2,
        RD_RSVD = 2'd3
    } rd_order_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        WAIT    = 3'd3,
        DONE    = 3'd4
    } rd_state_t;

    // Fibonacci taps for x^5 + x^3 + 1 (bits 4 and 2).
    localparam address_t LFSR_TAPS = 5'b10100;

    function automatic address_t lfsr_next(input address_t s);
        return {s[3:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/instr_result_model.sv
// Combinational reference model: opcode/op_a/op_b -> expected result.
// Ports: opc, op_a, op_b in; result (operand_d) out. DIV/MOD by 0 give 0.
module instr_result_model
    import instr_register_pkg::*;
(
    input  opcode_t  opc,
    input  operand_t op_a,
    input  operand_t op_b,
    output operand_d result
);

    operand_d a;
    operand_d b;

    assign a = operand_d'(op_a);
    assign b = operand_d'(op_b);

    always_comb begin
        result = '0;
        unique case (opc)
            PASSA:   result = a;
            PASSB:   result = b;
            ADD:     result = a + b;
            SUB:     result = a - b;
            MULT:    result = a * b;
            DIV:     result = (b == '0) ? '0 : a / b;
            MOD:     result = (b == '0) ? '0 : a % b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_reader.sv
// Read-side sequencer: walks read_pointer over a programmed range and
// streams each captured instruction_word out on a valid/ready port.
// Ports: clk, reset (async, active-high); start/base_addr/count/order
// launch a burst; read_pointer/instruction_word talk to the register;
// out_valid/out_ready/out_instr/out_addr stream beats; busy/done status;
// mismatch/pass_cnt/fail_cnt live only with INSTR_READER_CHECK_EN.
module instr_register_reader
    import instr_register_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  address_t             base_addr,
    input  logic [CNT_W-1:0]     count,
    input  rd_order_t            order,
    output address_t             read_pointer,
    input  instruction_t         instruction_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output instruction_t         out_instr,
    output address_t             out_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch,
    output logic [CNT_SAT_W-1:0] pass_cnt,
    output logic [CNT_SAT_W-1:0] fail_cnt
);

    rd_state_t        state;
    rd_order_t        ord_q;
    address_t         addr;
    address_t         lfsr;
    address_t         next_addr;
    logic [CNT_W-1:0] remaining;

    // 5-bit address arithmetic wraps modulo DEPTH on its own.
    always_comb begin
        next_addr = addr + 5'd1;
        unique case (ord_q)
            RD_DECR: next_addr = addr - 5'd1;
            RD_RAND: next_addr = lfsr_next(lfsr);
            default: next_addr = addr + 5'd1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ord_q        <= RD_INCR;
            addr         <= '0;
            lfsr         <= '0;
            remaining    <= '0;
            read_pointer <= '0;
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_addr     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= count;
                        ord_q     <= order;
                        // An all-zero LFSR would lock up; seed 1 instead.
                        lfsr      <= (base_addr == '0) ? address_t'(1)
                                                       : base_addr;
                        state     <= (count == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    read_pointer <= addr;
                    state        <= CAPTURE;
                end
                CAPTURE: begin
                    out_instr <= instruction_word;
                    out_addr  <= read_pointer;
                    out_valid <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end else begin
                            addr  <= next_addr;
                            lfsr  <= lfsr_next(lfsr);
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef INSTR_READER_CHECK_EN
    operand_d exp_res;
    logic     hit;

    instr_result_model u_model (
        .opc    (instruction_word.opc),
        .op_a   (instruction_word.op_a),
        .op_b   (instruction_word.op_b),
        .result (exp_res)
    );

    assign hit = (exp_res == instruction_word.rezultat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            mismatch <= 1'b0;
            if (state == IDLE && start) begin
                pass_cnt <= '0;
                fail_cnt <= '0;
            end else if (state == CAPTURE) begin
                // Registered so the verdict rises together with out_valid.
                mismatch <= !hit;
                if (hit && pass_cnt != '1) begin
                    pass_cnt <= pass_cnt + CNT_SAT_W'(1);
                end
                if (!hit && fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + CNT_SAT_W'(1);
                end
            end
        end
    end
`else
    assign mismatch = 1'b0;
    assign pass_cnt = '0;
    assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_register_reader.sv
// Scoreboard bench for instr_register_reader: random bursts and ready
// patterns checked against an address/result model kept in the bench.
module tb_instr_register_reader;
    import instr_register_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    address_t             base_addr;
    logic [CNT_W-1:0]     count;
    rd_order_t            order;
    address_t             read_pointer;
    instruction_t         instruction_word;
    logic                 out_valid;
    logic                 out_ready;
    instruction_t         out_instr;
    address_t             out_addr;
    logic                 busy;
    logic                 done;
    logic                 mismatch;
    logic [CNT_SAT_W-1:0] pass_cnt;
    logic [CNT_SAT_W-1:0] fail_cnt;

    always #5 clk = ~clk;

    instruction_t mem [DEPTH];
    assign instruction_word = mem[read_pointer];

    instr_register_reader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_addr        (base_addr),
        .count            (count),
        .order            (order),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_addr         (out_addr),
        .busy             (busy),
        .done             (done),
        .mismatch         (mismatch),
        .pass_cnt         (pass_cnt),
        .fail_cnt         (fail_cnt)
    );

    typedef struct {
        address_t     addr;
        instruction_t ins;
        bit           mm;
    } exp_t;

    exp_t sbq [$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   beats = 0;
    int   dones = 0;
    int   stalls = 0;
    int   hs_cyc = 0;
    int   done_cyc = 0;
    int   exp_pass = 0;
    int   exp_fail = 0;
    bit   rand_ready = 0;
    int   stall_on_beat = -1;
    int   stall_left = 0;

    task automatic check(input string name, input logic [159:0] act,
                         input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint ref_result(input instruction_t i);
        longint a = i.op_a;
        longint b = i.op_b;
        case (i.opc)
            PASSA: return a;
            PASSB: return b;
            ADD:   return a + b;
            SUB:   return a - b;
            MULT:  return a * b;
            DIV:   return (b == 0) ? 0 : a / b;
            MOD:   return (b == 0) ? 0 : a % b;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_mismatch(input instruction_t i);
`ifdef INSTR_READER_CHECK_EN
        return ref_result(i) != longint'(i.rezultat);
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (stall_on_beat == beats && stall_left > 0) begin
            out_ready <= 1'b0;
            if (out_valid) stall_left <= stall_left - 1;
        end else if (rand_ready) begin
            out_ready <= 1'($urandom_range(0, 1));
        end else begin
            out_ready <= 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake.
    bit           prev_stall = 0;
    bit           prev_valid = 0;
    bit           prev_done = 0;
    instruction_t prev_instr;
    address_t     prev_addr;
    exp_t         e;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
            prev_valid = 0;
            prev_done = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_instr", out_instr, prev_instr);
                check("stall_addr", out_addr, prev_addr);
                stalls++;
            end
            if (out_valid && !prev_valid && sbq.size() > 0)
                check("mismatch_beat", mismatch, sbq[0].mm);
            else
                check("mismatch_idle", mismatch, 0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got addr %0d expected none",
                             out_addr);
                end else begin
                    e = sbq.pop_front();
                    check("beat_addr", out_addr, e.addr);
                    check("beat_instr", out_instr, e.ins);
                end
                beats++;
                hs_cyc = cyc;
            end
            if (prev_done) begin
                check("busy_after_done", busy, 0);
                check("done_width", done, 0);
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_done = done;
            prev_instr = out_instr;
            prev_addr = out_addr;
        end
    end

    task automatic push_expect(input address_t b, input int n,
                               input rd_order_t o);
        int       ai = b;
        address_t l = (b == 0) ? address_t'(1) : b;
        exp_t     x;
        exp_pass = 0;
        exp_fail = 0;
        for (int i = 0; i < n; i++) begin
            x.addr = address_t'(ai);
            x.ins = mem[ai];
            x.mm = ref_mismatch(mem[ai]);
`ifdef INSTR_READER_CHECK_EN
            if (x.mm) exp_fail++;
            else exp_pass++;
`endif
            sbq.push_back(x);
            if (o == RD_DECR) begin
                ai = (ai + DEPTH - 1) % DEPTH;
            end else if (o == RD_RAND) begin
                l = {l[3:0], l[4] ^ l[2]};
                ai = l;
            end else begin
                ai = (ai + 1) % DEPTH;
            end
        end
    endtask

    task automatic pulse_start(input address_t b, input int n,
                               input rd_order_t o);
        start = 1'b1;
        base_addr = b;
        count = CNT_W'(n);
        order = o;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = address_t'($urandom);
        count = CNT_W'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy 1 expected 0");
        end
    endtask

    task automatic run_burst(input address_t b, input int n,
                             input rd_order_t o, input int poke_at);
        int d0;
        int k;
        wait_idle();
        push_expect(b, n, o);
        d0 = dones;
        @(posedge clk);
        #1;
        pulse_start(b, n, o);
        check("busy_after_start", busy, 1);
        k = 0;
        while (dones == d0 && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
            if (k == poke_at) pulse_start(address_t'(b + 7), 9, RD_DECR);
        end
        if (dones == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done");
        end
        @(negedge clk);
        #1;
        check("sb_empty", sbq.size(), 0);
        if (n > 0) check("done_latency", done_cyc - hs_cyc, 1);
        check("pass_cnt", pass_cnt, exp_pass);
        check("fail_cnt", fail_cnt, exp_fail);
        sbq.delete();
    endtask

    task automatic check_zero(input string name);
        check({name, "_rp"}, read_pointer, 0);
        check({name, "_valid"}, out_valid, 0);
        check({name, "_instr"}, out_instr, 0);
        check({name, "_addr"}, out_addr, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_pass"}, pass_cnt, 0);
        check({name, "_fail"}, fail_cnt, 0);
    endtask

    initial begin
        int b0;
        int d0;
        int k;
        instruction_t t;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        order = RD_INCR;
        for (int i = 0; i < DEPTH; i++) begin
            t.opc = opcode_t'($urandom_range(0, 7));
            t.op_a = operand_t'($urandom_range(0, 400)) - 200;
            t.op_b = operand_t'($urandom_range(0, 20)) - 10;
            t.rezultat = $urandom_range(0, 1) ? ref_result(t)
                                              : operand_d'($urandom);
            mem[i] = t;
        end
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        run_burst(5'd0, 3, RD_INCR, 0);
        run_burst(5'd1, 3, RD_DECR, 0);
        run_burst(5'd30, 3, RD_INCR, 0);

        stall_left = 4;
        stall_on_beat = beats + 1;
        k = stalls;
        run_burst(5'd4, 3, RD_INCR, 0);
        check("stall_seen", (stalls - k) >= 4, 1);
        stall_on_beat = -1;

        b0 = beats;
        run_burst(5'd9, 0, RD_INCR, 0);
        check("count0_beats", beats - b0, 0);
        run_burst(5'd12, 4, RD_INCR, 5);
        run_burst(5'd0, 5, RD_RAND, 0);
        run_burst(5'd17, 6, RD_RSVD, 0);

        wait_idle();
        push_expect(5'd20, 5, RD_INCR);
        @(posedge clk);
        #1;
        b0 = beats;
        d0 = dones;
        pulse_start(5'd20, 5, RD_INCR);
        k = 0;
        while (beats < b0 + 2 && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("pre_reset_beats", beats - b0, 2);
        #3;
        reset = 1'b1;
        #1;
        check_zero("midreset");
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_on_reset", dones - d0, 0);
        run_burst(5'd0, 1, RD_INCR, 0);

`ifdef INSTR_READER_CHECK_EN
        mem[0] = '{opc: ADD, op_a: 5, op_b: 3, rezultat: 8};
        mem[1] = '{opc: MOD, op_a: 7, op_b: 0, rezultat: 0};
        mem[2] = '{opc: SUB, op_a: -4, op_b: 6, rezultat: 9};
        run_burst(5'd0, 3, RD_INCR, 0);
        check("t6_pass", pass_cnt, 2);
        check("t6_fail", fail_cnt, 1);
`endif

        rand_ready = 1;
        for (int i = 0; i < 20; i++) begin
            run_burst(address_t'($urandom), $urandom_range(0, 32),
                      rd_order_t'($urandom_range(0, 3)), 0);
        end
        rand_ready = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
